mac_accumulator: RTL and testbench

- Downstream consumer of the generic multiplier's 2*OperandWidth product.
- Accumulates a programmed number of unsigned products into a wide accumulator, for dot-product and MAC exercises in the course datapath.
- Product input uses a valid/ready handshake; the result output uses a valid/ready handshake.
- Sits between the multiplier (with or without output register) and the consuming register interface or next stage.

---
 rtl/mac_accumulator.sv | 128 ++++++++++++
 tb/tb_mac_accumulator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmed number of unsigned products into a wide
// accumulator. Products arrive on a valid/ready handshake. The sum and a sticky
// carry-out flag are presented on a second valid/ready handshake.
module mac_accumulator #(
    parameter int ProductWidth = 64,
    parameter int AccWidth     = 72,
    parameter int LenWidth     = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [LenWidth-1:0]     len_i,
    input  logic                    prod_valid_i,
    output logic                    prod_ready_o,
    input  logic [ProductWidth-1:0] product_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [AccWidth-1:0]     result_o,
    output logic                    overflow_o,
    output logic                    busy_o
);

    // The product is zero-extended into the accumulator, so the accumulator
    // must be at least as wide as the product.
    if (AccWidth < ProductWidth) begin : g_width_check
        $error("mac_accumulator: AccWidth must be >= ProductWidth");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AccWidth-1:0] acc_q, acc_d;
    logic [LenWidth-1:0] count_q, count_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic                ovf_q, ovf_d;

    // One bit wider than the accumulator so the top bit is the carry-out.
    logic [AccWidth:0]   sum_ext;
    logic [LenWidth-1:0] count_inc;

    assign sum_ext   = {1'b0, acc_q} + (AccWidth + 1)'(product_i);
    assign count_inc = count_q + LenWidth'(1);

    // Next-state logic: burst control, accumulation and abort.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    if (len_i != '0) begin
                        len_d   = len_i;
                        state_d = ACCUM;
                    end else begin
                        // Empty burst: report a zero result straight away.
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                // Ready is implied by the state, so valid alone completes the handshake.
                if (prod_valid_i) begin
                    acc_d   = sum_ext[AccWidth-1:0];
                    ovf_d   = ovf_q | sum_ext[AccWidth];
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A start in this cycle is deliberately not looked at.
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over every handshake in the same cycle.
        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            len_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs depend on registered state only; nothing is combinational from inputs.
    assign prod_ready_o = (state_q == ACCUM);
    assign res_valid_o  = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign result_o     = acc_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed bursts against two instances (72-bit default and
// an 8-bit accumulator that can wrap), checked against a sum-based model every
// cycle plus hand-computed literal expectations.
module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [63:0] product;
    logic        res_ready;

    logic        prod_ready_a, res_valid_a, ovf_a, busy_a;
    logic [71:0] result_a;
    logic        prod_ready_b, res_valid_b, ovf_b, busy_b;
    logic [7:0]  result_b;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 1'b0;

    mac_accumulator dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .start_i      (start),
        .len_i        (len),
        .prod_valid_i (prod_valid),
        .prod_ready_o (prod_ready_a),
        .product_i    (product),
        .res_valid_o  (res_valid_a),
        .res_ready_i  (res_ready),
        .result_o     (result_a),
        .overflow_o   (ovf_a),
        .busy_o       (busy_a)
    );

    mac_accumulator #(
        .ProductWidth (8),
        .AccWidth     (8),
        .LenWidth     (8)
    ) dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .start_i      (start),
        .len_i        (len),
        .prod_valid_i (prod_valid),
        .prod_ready_o (prod_ready_b),
        .product_i    (product[7:0]),
        .res_valid_o  (res_valid_b),
        .res_ready_i  (res_ready),
        .result_o     (result_b),
        .overflow_o   (ovf_b),
        .busy_o       (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 collecting, 2 result pending. Sums are kept with
    // headroom so wrap-around and carry-out follow from plain arithmetic.
    int          m_mode = 0;
    int          m_remaining = 0;
    logic [79:0] m_sum_a = '0;
    logic [15:0] m_sum_b = '0;

    always begin
        @(posedge clk);
        if (!rst_n || clear) begin
            m_mode  = 0;
            m_sum_a = '0;
            m_sum_b = '0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_sum_a = '0;
                    m_sum_b = '0;
                    if (len != 0) begin
                        m_mode      = 1;
                        m_remaining = int'(len);
                    end else begin
                        m_mode = 2;
                    end
                end
                1: if (prod_valid) begin
                    m_sum_a     = m_sum_a + {16'b0, product};
                    m_sum_b     = m_sum_b + {8'b0, product[7:0]};
                    m_remaining = m_remaining - 1;
                    if (m_remaining == 0) m_mode = 2;
                end
                default: if (res_ready) m_mode = 0;
            endcase
        end
        @(negedge clk);
        if (check_en) begin
            chk("a.prod_ready", 80'(prod_ready_a), 80'(m_mode == 1));
            chk("a.res_valid",  80'(res_valid_a),  80'(m_mode == 2));
            chk("a.busy",       80'(busy_a),       80'(m_mode != 0));
            chk("b.prod_ready", 80'(prod_ready_b), 80'(m_mode == 1));
            chk("b.res_valid",  80'(res_valid_b),  80'(m_mode == 2));
            chk("b.busy",       80'(busy_b),       80'(m_mode != 0));
            if (m_mode != 1) begin
                chk("a.result",   80'(result_a), 80'(m_sum_a[71:0]));
                chk("a.overflow", 80'(ovf_a),    80'(|m_sum_a[79:72]));
                chk("b.result",   80'(result_b), 80'(m_sum_b[7:0]));
                chk("b.overflow", 80'(ovf_b),    80'(|m_sum_b[15:8]));
            end
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [63:0] p);
        prod_valid = 1'b1;
        product    = p;
        step();
        prod_valid = 1'b0;
    endtask

    task automatic begin_burst(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; len = '0;
        prod_valid = 1'b0; product = '0; res_ready = 1'b0;
        step();
        check_en = 1'b1;
        step();
        chk("reset.busy", 80'(busy_a), 80'(0));
        chk("reset.result", 80'(result_a), 80'(0));
        rst_n = 1'b1;
        step();

        // Basic burst 3+5+7+9.
        begin_burst(8'd4);
        push(64'd3);
        push(64'd5);
        push(64'd7);
        chk("basic.valid_before_last", 80'(res_valid_a), 80'(0));
        push(64'd9);
        chk("basic.res_valid", 80'(res_valid_a), 80'(1));
        chk("basic.result",    80'(result_a),    80'(24));
        chk("basic.overflow",  80'(ovf_a),       80'(0));
        step();
        drain();

        // Backpressure on both sides.
        begin_burst(8'd2);
        push(64'd10);
        step();
        step();
        push(64'd20);
        for (int i = 0; i < 5; i++) begin
            chk("bp.result",     80'(result_a),     80'(30));
            chk("bp.prod_ready", 80'(prod_ready_a), 80'(0));
            chk("bp.res_valid",  80'(res_valid_a),  80'(1));
            step();
        end
        drain();
        chk("bp.idle_busy", 80'(busy_a), 80'(0));

        // Wrap in the 8-bit instance: 200+100 = 300 -> 44 with carry.
        begin_burst(8'd2);
        push(64'd200);
        push(64'd100);
        chk("ovf.result_b",   80'(result_b), 80'(44));
        chk("ovf.overflow_b", 80'(ovf_b),    80'(1));
        chk("ovf.result_a",   80'(result_a), 80'(300));
        chk("ovf.overflow_a", 80'(ovf_a),    80'(0));
        drain();
        begin_burst(8'd1);
        push(64'd1);
        chk("ovf.next_result_b",   80'(result_b), 80'(1));
        chk("ovf.next_overflow_b", 80'(ovf_b),    80'(0));
        drain();

        // Zero length with a product on offer that must not be taken.
        prod_valid = 1'b1;
        product    = 64'd99;
        begin_burst(8'd0);
        chk("zero.res_valid",  80'(res_valid_a),  80'(1));
        chk("zero.result",     80'(result_a),     80'(0));
        chk("zero.prod_ready", 80'(prod_ready_a), 80'(0));
        drain();
        prod_valid = 1'b0;
        step();

        // Abort after two of four products, with a product offered in the clear cycle.
        begin_burst(8'd4);
        push(64'd2);
        push(64'd3);
        clear      = 1'b1;
        prod_valid = 1'b1;
        product    = 64'd50;
        step();
        clear      = 1'b0;
        prod_valid = 1'b0;
        chk("abort.busy",       80'(busy_a),       80'(0));
        chk("abort.prod_ready", 80'(prod_ready_a), 80'(0));
        chk("abort.result",     80'(result_a),     80'(0));
        begin_burst(8'd1);
        push(64'd11);
        chk("abort.new_result", 80'(result_a), 80'(11));
        drain();

        // Reset in the middle of a burst.
        begin_burst(8'd3);
        push(64'd8);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst.busy",       80'(busy_a),       80'(0));
        chk("rst.prod_ready", 80'(prod_ready_a), 80'(0));
        chk("rst.res_valid",  80'(res_valid_a),  80'(0));
        chk("rst.result",     80'(result_a),     80'(0));

        // Start while in DONE, including the cycle that returns to IDLE.
        begin_burst(8'd2);
        push(64'd4);
        push(64'd6);
        start = 1'b1;
        len   = 8'd5;
        step();
        chk("done_start.res_valid", 80'(res_valid_a), 80'(1));
        chk("done_start.result",    80'(result_a),    80'(10));
        res_ready = 1'b1;
        step();
        start     = 1'b0;
        res_ready = 1'b0;
        chk("done_start.busy",   80'(busy_a),   80'(0));
        chk("done_start.result_hold", 80'(result_a), 80'(10));
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
